// File: rtl/filter_pkg.sv
// Shared types and constants for the moving-average filter.
// Sample width, default window depth and the control FSM encoding.
package filter_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int LOG2_N_DEF = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fir_average_filter_if.sv
// Sample stream bundle between the CODEC side and the filter.
// The master drives strobe and sample; the slave returns the average.
interface fir_average_filter_if
    import filter_pkg::*;
();

    logic                       enable;
    logic signed [SAMPLE_W-1:0] data_in;
    logic signed [SAMPLE_W-1:0] data_out;
    logic                       primed;

    modport master (
        output enable,
        output data_in,
        input  data_out,
        input  primed
    );

    modport slave (
        input  enable,
        input  data_in,
        output data_out,
        output primed
    );

endinterface

// File: rtl/sample_ring.sv
// Circular buffer: exposes the entry at the write pointer (the oldest)
// and replaces it with the new value on each write.
module sample_ring #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic [W-1:0] oldest_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    assign oldest_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
            ptr_q        <= ptr_d;
        end
    end

endmodule

// File: rtl/fir_average_filter.sv
// Moving average over the last 2^LOG2_N samples using a running sum
// of pre-scaled samples; output registered with one-clock latency.
module fir_average_filter
    import filter_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_average_filter_if.slave  bus
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;

    logic signed [SAMPLE_W-1:0] scaled;
    logic signed [SAMPLE_W-1:0] oldest;
    logic signed [SAMPLE_W-1:0] acc_q;
    logic signed [SAMPLE_W-1:0] acc_d;
    logic signed [SAMPLE_W-1:0] dout_q;
    logic [CNT_W-1:0]           fill_q;
    logic                       primed_q;
    state_e                     state_q;

    // Scaling before summing keeps the N-term sum inside SAMPLE_W bits.
    assign scaled = bus.data_in >>> LOG2_N;
    assign acc_d  = acc_q + scaled - oldest;

    sample_ring #(
        .W     (SAMPLE_W),
        .DEPTH (N)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bus.enable),
        .wr_data_i (scaled),
        .oldest_o  (oldest)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            fill_q   <= '0;
            primed_q <= 1'b0;
            acc_q    <= '0;
            dout_q   <= '0;
        end else if (bus.enable) begin
            acc_q  <= acc_d;
            dout_q <= acc_d;
            unique case (state_q)
                FILL: begin
                    fill_q <= fill_q + CNT_W'(1);
                    if (fill_q == CNT_W'(N - 1)) begin
                        state_q  <= RUN;
                        primed_q <= 1'b1;
                    end
                end
                RUN: begin
                    primed_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out = dout_q;
    assign bus.primed   = primed_q;

endmodule

// File: tb/tb_fir_average_filter.sv
// Randomised and directed stimulus against a queue-based model of
// the moving average of the last N scaled samples.
module tb_fir_average_filter;
    import filter_pkg::*;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   hist[$];
    int   cnt;

    fir_average_filter_if bus ();

    fir_average_filter #(
        .LOG2_N (LOG2_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic model_clear();
        hist.delete();
        cnt = 0;
    endtask

    task automatic model_push(input logic signed [SAMPLE_W-1:0] d);
        int v;
        v = d;
        v = v >>> LOG2_N;
        hist.push_back(v);
        if (hist.size() > N) void'(hist.pop_front());
        cnt++;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dout"}, bus.data_out, model_sum());
        check({tag, "_primed"}, {31'b0, bus.primed}, (cnt >= N) ? 1 : 0);
    endtask

    task automatic step(input string tag, input logic en,
                        input logic signed [SAMPLE_W-1:0] d);
        @(negedge clk);
        bus.enable  = en;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (en) model_push(d);
        check_model(tag);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #3;
        reset       = 1'b1;
        bus.enable  = 1'b1;
        bus.data_in = SAMPLE_W'($urandom);
        #1;
        model_clear();
        check("rst_async_dout", bus.data_out, 0);
        check("rst_async_primed", {31'b0, bus.primed}, 0);
        @(posedge clk);
        #1;
        check_model("rst_en_ignored");
        @(negedge clk);
        reset      = 1'b0;
        bus.enable = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.data_in = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step("idle", 1'b0, '0);

        for (int i = 0; i < 9; i++) begin
            step("fill800", 1'b1, 24'sd800);
            check("fill800_exp", bus.data_out, (i < 8) ? 100 * (i + 1) : 800);
        end

        for (int i = 0; i < 8; i++) begin
            step("neg8", 1'b1, -24'sd8);
            check("neg8_exp", bus.data_out, 800 - 101 * (i + 1));
        end

        for (int i = 0; i < 20; i++) step("full", 1'b1, 24'sh7FFFFF);
        check("full_settle", bus.data_out, 32'sh7FFFF8);

        for (int i = 0; i < 10; i++) begin
            step("hold", 1'b0, SAMPLE_W'($urandom));
        end
        check("hold_exp", bus.data_out, 32'sh7FFFF8);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, SAMPLE_W'($urandom));
        mid_reset();
        step("post_rst", 1'b1, 24'sd80);
        check("post_rst_10", bus.data_out, 10);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                step("rand", ($urandom_range(0, 3) != 0),
                     SAMPLE_W'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_average_filter.md
FIR_AVERAGE_FILTER -- requirements
Module: fir_average_filter

Interface
REQ-001 Parameter: LOG2_N, default 3, log2 of averaging window depth N (N = 2^LOG2_N, legal 1..6).
REQ-002 clk  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  sample strobe; high when the audio CODEC can both produce and accept a new sample; one sample consumed per high cycle.
REQ-005 data_in  input  24  signed two's-complement noisy sample (audio plus noise).
REQ-006 data_out  output  24  signed moving average of the last N samples, registered.
REQ-007 primed  output  1  high once N samples have been absorbed since reset.

Function
REQ-008 The block SHALL keep a circular buffer of N entries, each holding data_in arithmetically shifted right by LOG2_N (sign-preserving floor divide).
REQ-009 On each clk edge with enable high, it SHALL compute acc_next = acc + (data_in >>> LOG2_N) - oldest, with oldest being the entry at the write pointer.
REQ-010 On that same edge it SHALL overwrite that entry, advance the write pointer modulo N, load acc with acc_next, and load data_out with acc_next; latency is one clock.
REQ-011 The accumulator SHALL be 24 bits signed; pre-scaling guarantees no overflow, and no saturation logic is added.
REQ-012 The write pointer SHALL wrap from N-1 to 0 with no stall or skipped entry.
REQ-013 With enable low, buffer, pointer, acc, data_out, and primed SHALL hold their values.
REQ-014 Control FSM states: FILL and RUN. FILL increments a fill counter per enable; the enable that absorbs sample N moves to RUN and sets primed on that edge. RUN is held until reset.
REQ-015 During FILL, unwritten entries read as zero, so data_out is the partial sum of scaled samples received so far.
REQ-016 Back-to-back enable on every cycle SHALL be supported at full rate.

Reset
REQ-017 Asserting reset at any time, including mid-stream, SHALL asynchronously clear:
- all buffer entries, write pointer, fill counter, and acc to 0;
- data_out to 0 and primed to 0;
- the FSM to FILL.
REQ-018 An enable that coincides with reset assertion SHALL be ignored.
REQ-019 The first enable after reset release SHALL be processed normally.

Structure
REQ-020 A shared package filter_pkg SHALL hold:
- SAMPLE_W = 24;
- the default LOG2_N;
- the enum type for the FSM states (FILL, RUN).
REQ-021 The circular buffer (storage plus wrapping pointer, read-oldest/write-new per enable) SHALL be a sub-module named sample_ring, parameterised by width and depth.
REQ-022 Accumulator, FSM, and output register SHALL reside in fir_average_filter.

Verification (LOG2_N = 3, N = 8)
REQ-023 Reset, then 5 idle cycles -> data_out = 0, primed = 0.
REQ-024 Eight enables with data_in = 800 -> data_out 100, 200, ..., 800; primed rises with the 8th sample; a 9th 800 keeps data_out at 800.
REQ-025 Primed at 800, then eight enables of data_in = -8 -> each step subtracts 100 and adds -1; final data_out = -8.
REQ-026 Enable held high for 20 consecutive cycles with data_in = 0x7FFFFF -> data_out settles at 8 × 0x0FFFFF = 0x7FFFF8; no overflow; pointer wraps cleanly.
REQ-027 Enable low for 10 cycles while data_in toggles -> data_out unchanged.
REQ-028 Reset pulse after 5 samples -> data_out = 0 and primed = 0 immediately; next sample of 80 -> data_out = 10.
